// File: rtl/uart_sram_transmitter.sv
// Streams a block of 16-bit SRAM words out an 8N1 serial line, high byte first.
// One word per pass: address, wait out SRAM latency, capture, then two back-to-back frames.
module uart_sram_transmitter #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        Start,
  input  logic [17:0] Base_address,
  input  logic [17:0] Word_count,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic        SRAM_we_n,
  output logic        UART_TX_O,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WAIT, S_CAPTURE, S_SEND_HI, S_SEND_LO, S_NEXT, S_DONE
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [3:0]  BIT_STOP  = 4'd9;

  state_t      state_q, state_d;
  logic [17:0] addr_q, addr_d;
  logic [17:0] remaining_q, remaining_d;
  logic [17:0] sram_addr_q, sram_addr_d;
  logic [15:0] word_buf_q, word_buf_d;
  logic [15:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;
  logic        tx_q, tx_d;

  // Line level for a given frame position: index 0 is the start bit, 1..8 data LSB first, 9 stop.
  function automatic logic lineLevel(input state_t st, input logic [3:0] idx, input logic [15:0] word);
    logic [7:0] b;
    logic       lvl;
    b   = (st == S_SEND_HI) ? word[15:8] : word[7:0];
    lvl = 1'b1;
    if (st == S_SEND_HI || st == S_SEND_LO) begin
      if (idx == 4'd0)
        lvl = 1'b0;
      else if (idx <= 4'd8)
        lvl = b[3'(idx - 4'd1)];
    end
    return lvl;
  endfunction

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      sram_addr_q <= '0;
      word_buf_q  <= '0;
      baud_q      <= '0;
      bit_q       <= '0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      sram_addr_q <= sram_addr_d;
      word_buf_q  <= word_buf_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    sram_addr_d = sram_addr_q;
    word_buf_d  = word_buf_q;
    baud_d      = baud_q;
    bit_d       = bit_q;

    case (state_q)
      // An empty request detours through S_NEXT so Done lands two cycles after Start.
      S_IDLE: begin
        if (Start) begin
          addr_d      = Base_address;
          remaining_d = Word_count;
          state_d     = (Word_count == '0) ? S_NEXT : S_ADDR;
        end
      end
      S_ADDR:    state_d = S_WAIT;
      S_WAIT:    state_d = S_CAPTURE;
      S_CAPTURE: begin
        word_buf_d = SRAM_read_data;
        state_d    = S_SEND_HI;
      end
      S_SEND_HI, S_SEND_LO: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == BIT_STOP) begin
            bit_d   = '0;
            state_d = (state_q == S_SEND_HI) ? S_SEND_LO : S_NEXT;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_NEXT: begin
        addr_d      = addr_q + 18'd1;
        remaining_d = (remaining_q == '0) ? '0 : remaining_q - 18'd1;
        state_d     = (remaining_q <= 18'd1) ? S_DONE : S_ADDR;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Address register loads as the read begins so it is visible during S_ADDR.
    if (state_d == S_ADDR)
      sram_addr_d = addr_d;

    tx_d = lineLevel(state_d, bit_d, word_buf_d);
  end

  assign SRAM_address = sram_addr_q;
  assign SRAM_we_n    = 1'b1;
  assign UART_TX_O    = tx_q;
  assign Busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign Done         = (state_q == S_DONE);

endmodule

// File: tb/tb_uart_sram_transmitter.sv
// Directed bench for uart_sram_transmitter: records the serial line per cycle after each
// Start and compares it against a timing model and a byte decoder.
module tb_uart_sram_transmitter;

  localparam int B    = 4;
  localparam int MAXC = 512;

  logic        CLOCK_50_I = 1'b0;
  logic        resetn;
  logic        Start;
  logic [17:0] Base_address;
  logic [17:0] Word_count;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data = 16'h0;
  logic        SRAM_we_n;
  logic        UART_TX_O;
  logic        Busy;
  logic        Done;

  logic [15:0] rdPipe = 16'h0;

  logic        txRec   [0:MAXC-1];
  logic        doneRec [0:MAXC-1];
  logic        busyRec [0:MAXC-1];
  logic [17:0] addrRec [0:MAXC-1];
  int          doneCycle;
  int          lastCycle;

  logic [15:0] expWords [0:3];
  int          expN;

  int checks   = 0;
  int failures = 0;

  uart_sram_transmitter #(.BAUD_DIV(B)) dut (
    .CLOCK_50_I    (CLOCK_50_I),
    .resetn        (resetn),
    .Start         (Start),
    .Base_address  (Base_address),
    .Word_count    (Word_count),
    .SRAM_address  (SRAM_address),
    .SRAM_read_data(SRAM_read_data),
    .SRAM_we_n     (SRAM_we_n),
    .UART_TX_O     (UART_TX_O),
    .Busy          (Busy),
    .Done          (Done)
  );

  always #5 CLOCK_50_I = ~CLOCK_50_I;

  function automatic logic [15:0] memRead(input logic [17:0] a);
    logic [15:0] d;
    case (a)
      18'h00010: d = 16'hA53C;
      18'h24000: d = 16'h0001;
      18'h24001: d = 16'hFF00;
      18'h24002: d = 16'h8080;
      18'h3FFFF: d = 16'h1234;
      18'h00000: d = 16'hABCD;
      default:   d = 16'hDEAD;
    endcase
    return d;
  endfunction

  // SRAM model: data valid two cycles after the address is presented.
  always @(posedge CLOCK_50_I) begin
    rdPipe         <= memRead(SRAM_address);
    SRAM_read_data <= rdPipe;
  end

  function automatic logic expLine(input int c);
    int         t0;
    int         o;
    int         bp;
    logic [7:0] by;
    logic       lvl;
    lvl = 1'b1;
    for (int k = 0; k < expN; k++) begin
      t0 = 4 + k * (20 * B + 4);
      if (c >= t0 && c < t0 + 20 * B) begin
        o  = c - t0;
        by = (o < 10 * B) ? expWords[k][15:8] : expWords[k][7:0];
        bp = (o % (10 * B)) / B;
        if (bp == 0)      lvl = 1'b0;
        else if (bp == 9) lvl = 1'b1;
        else              lvl = by[bp - 1];
      end
    end
    return lvl;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Pulses Start at the current negedge (cycle 0) and records outputs at each later negedge.
  task automatic applyStimulus(input logic [17:0] base, input logic [17:0] cnt, input int pulseAt);
    int c;
    for (int i = 0; i < MAXC; i++) begin
      txRec[i] = 1'b1; doneRec[i] = 1'b0; busyRec[i] = 1'b0; addrRec[i] = '0;
    end
    doneCycle    = -1;
    lastCycle    = 0;
    Base_address = base;
    Word_count   = cnt;
    Start        = 1'b1;
    @(negedge CLOCK_50_I);
    Base_address = 18'h2AAAA;
    Word_count   = 18'd5;
    c = 1;
    while (c < MAXC) begin
      txRec[c]   = UART_TX_O;
      doneRec[c] = Done;
      busyRec[c] = Busy;
      addrRec[c] = SRAM_address;
      lastCycle  = c;
      if (Done === 1'b1 && doneCycle < 0) doneCycle = c;
      Start = (c == pulseAt);
      if (doneCycle >= 0 && c >= doneCycle + 2) break;
      c++;
      @(negedge CLOCK_50_I);
    end
    Start = 1'b0;
  endtask

  task automatic checkTransfer(input string name, input logic [17:0] base);
    int         expDone;
    int         mism;
    int         c;
    int         s;
    int         decN;
    logic [7:0] decBytes [0:15];
    logic [7:0] b;
    logic [7:0] expB;
    expDone = (expN == 0) ? 2 : 4 + expN * 20 * B + (expN - 1) * 4 + 1;
    checkOutput({name, "_done_cycle"}, doneCycle, expDone);
    if (doneCycle >= 0) begin
      mism = 0;
      for (int i = 1; i <= doneCycle + 1; i++)
        if (txRec[i] !== expLine(i)) mism++;
      checkOutput({name, "_wave_mismatches"}, mism, 0);
      checkOutput({name, "_busy_c1"}, busyRec[1], 1'b1);
      checkOutput({name, "_busy_at_done"}, busyRec[doneCycle], 1'b0);
      checkOutput({name, "_done_width"}, doneRec[doneCycle + 1], 1'b0);
      checkOutput({name, "_busy_after"}, busyRec[doneCycle + 1], 1'b0);
      for (int k = 0; k < expN; k++)
        checkOutput($sformatf("%s_addr%0d", name, k), addrRec[1 + k * (20 * B + 4)], 18'(base + 18'(k)));
      decN = 0;
      c = 1;
      while (c <= doneCycle && decN < 16) begin
        if (txRec[c] === 1'b0 && c + 10 * B < MAXC) begin
          s = c;
          for (int i = 0; i < 8; i++) b[i] = txRec[s + B * (i + 1) + B / 2];
          decBytes[decN] = b;
          decN++;
          c = s + 10 * B;
        end else begin
          c++;
        end
      end
      checkOutput({name, "_byte_count"}, decN, 2 * expN);
      for (int k = 0; k < 2 * expN && k < decN; k++) begin
        expB = (k % 2 == 0) ? expWords[k / 2][15:8] : expWords[k / 2][7:0];
        checkOutput($sformatf("%s_byte%0d", name, k), decBytes[k], expB);
      end
    end
  endtask

  initial begin
    int highs;
    resetn       = 1'b0;
    Start        = 1'b0;
    Base_address = '0;
    Word_count   = '0;
    repeat (2) @(negedge CLOCK_50_I);
    checkOutput("reset_tx", UART_TX_O, 1'b1);
    checkOutput("reset_busy", Busy, 1'b0);
    checkOutput("reset_done", Done, 1'b0);
    checkOutput("reset_addr", SRAM_address, 18'h0);
    checkOutput("reset_we_n", SRAM_we_n, 1'b1);
    resetn = 1'b1;
    repeat (3) @(negedge CLOCK_50_I);

    $display("[TB] single word");
    expN = 1; expWords[0] = 16'hA53C;
    applyStimulus(18'h00010, 18'd1, 0);
    checkTransfer("single", 18'h00010);
    checkOutput("single_c3_high", txRec[3], 1'b1);
    checkOutput("single_c4_start", txRec[4], 1'b0);
    repeat (3) @(negedge CLOCK_50_I);

    $display("[TB] three words with ignored Start");
    expN = 3; expWords[0] = 16'h0001; expWords[1] = 16'hFF00; expWords[2] = 16'h8080;
    applyStimulus(18'h24000, 18'd3, 30);
    checkTransfer("multi", 18'h24000);
    highs = 0;
    for (int i = 80; i < 88; i++) if (txRec[i] === 1'b1) highs++;
    checkOutput("multi_gap_high", highs, 8);
    checkOutput("multi_gap_pre", txRec[79], 1'b0);
    checkOutput("multi_gap_post", txRec[88], 1'b0);
    repeat (3) @(negedge CLOCK_50_I);

    $display("[TB] zero count");
    expN = 0;
    applyStimulus(18'h00100, 18'd0, 0);
    checkTransfer("zero", 18'h00100);
    checkOutput("zero_addr_hold", addrRec[2], 18'h24002);
    repeat (3) @(negedge CLOCK_50_I);

    $display("[TB] address wrap");
    expN = 2; expWords[0] = 16'h1234; expWords[1] = 16'hABCD;
    applyStimulus(18'h3FFFF, 18'd2, 0);
    checkTransfer("wrap", 18'h3FFFF);
    repeat (3) @(negedge CLOCK_50_I);

    $display("[TB] reset mid-byte");
    Base_address = 18'h3FFFF;
    Word_count   = 18'd1;
    Start        = 1'b1;
    @(negedge CLOCK_50_I);
    Start = 1'b0;
    repeat (16) @(negedge CLOCK_50_I);
    checkOutput("midrst_pre_tx", UART_TX_O, 1'b0);
    #2 resetn = 1'b0;
    #1;
    checkOutput("midrst_tx", UART_TX_O, 1'b1);
    checkOutput("midrst_busy", Busy, 1'b0);
    checkOutput("midrst_done", Done, 1'b0);
    checkOutput("midrst_addr", SRAM_address, 18'h0);
    @(negedge CLOCK_50_I);
    resetn = 1'b1;
    repeat (5) @(negedge CLOCK_50_I);
    checkOutput("midrst_after_tx", UART_TX_O, 1'b1);
    checkOutput("midrst_after_busy", Busy, 1'b0);
    expN = 1; expWords[0] = 16'hA53C;
    applyStimulus(18'h00010, 18'd1, 0);
    checkTransfer("fresh", 18'h00010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
